timer_periph: RTL and testbench
===============================

TIMER_PERIPH -- requirements
Module: timer_periph

Interface
REQ-001 Parameter TCR_ADDR, default 12'h504: control register address.
REQ-002 Parameter TCNT_ADDR, default 12'h505: counter register address.
REQ-003 Parameter TCMP_ADDR, default 12'h506: compare register address.
REQ-004 Parameter TSR_ADDR, default 12'h507: status register address.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 addr  in  12  bus address from core load/store unit.
REQ-008 wrData  in  32  store data.
REQ-009 wrEn  in  1  store strobe, one cycle per store.
REQ-010 rdEn  in  1  peripheral load strobe, one cycle per load.
REQ-011 dataOut  out  32  registered read data.
REQ-012 outEn  out  1  read-data-valid, drives the core data-bus mux select.
REQ-013 irq  out  1  level interrupt request.
REQ-014 pwm  out  1  PWM output (see Configuration).

Function
REQ-015 Decode: full 12-bit equality against the four addresses; any other address is ignored on write and gives no outEn on read.
REQ-016 Read latency is exactly 1 cycle: rdEn with a hit at cycle N causes outEn=1 and dataOut=register value as sampled at N, during cycle N+1 only; otherwise outEn=0 and dataOut=0.
REQ-017 Writes take effect at the edge ending the wrEn cycle; rdEn and wrEn to the same register in one cycle returns the pre-write value.
REQ-018 TCR fields: [0] EN, [1] PERIODIC (1=periodic, 0=one-shot), [2] IE, [31:16] PRESC; other bits read 0.
REQ-019 Prescaler: while EN=1, a 16-bit counter produces a one-cycle tick every PRESC+1 clocks; PRESC=0 ticks every cycle.
REQ-020 Clearing EN resets the prescaler counter to 0 and holds TCNT.
REQ-021 On a tick: if TCNT==TCMP, then TCNT<=0 and TSR.MATCH<=1, and EN<=0 when PERIODIC=0; else TCNT<=TCNT+1 (32-bit, wraps 32'hFFFFFFFF->0 without setting MATCH).
REQ-022 TCMP=0 with EN=1 produces MATCH on every tick.
REQ-023 Core write to TCNT in the same cycle as a tick: the written value wins, and no increment or match occurs that cycle.
REQ-024 Core write to TCR in a tick cycle: the written value wins over the one-shot EN clear.
REQ-025 TSR [0] MATCH: sticky; writing 1 to bit 0 clears it; writing 0 has no effect; a set and a clear in the same cycle leave it set.
REQ-026 irq = TSR.MATCH & TCR.IE, combinational from registers.

Reset
REQ-027 On rst: TCR, TCNT, TCMP, TSR, prescaler = 0; dataOut=0; outEn=0; irq=0; pwm=0.
REQ-028 Reset asserted mid-read suppresses the pending outEn.

Configuration
REQ-029 Macro TIMER_PWM_EN defined: pwm is registered, equal to EN & (TCNT < TCMP), updated every clock.
REQ-030 TIMER_PWM_EN undefined: pwm tied to 0 and no comparator logic is generated; the port remains.

Structure
REQ-031 Package timer_pkg holds the default address constants, the TCR bit-position constants, and a packed struct typedef for TCR.
REQ-032 A sub-module timer_prescaler (inputs en, presc; output tick) implements the prescaler.

Verification
REQ-033 Write TCMP=3, then TCR=32'h0000_0003 -> TCNT counts 0,1,2,3,0 per clock; MATCH set on the 3->0 tick; irq stays 0 (IE=0).
REQ-034 TCR=32'h0002_0005 (PRESC=2, one-shot, IE) with TCMP=1 -> tick every 3 clocks; MATCH and irq rise after 6 clocks; EN reads 0 afterwards.
REQ-035 Read TSR with MATCH=1 -> outEn=1 and dataOut=1 exactly one cycle after rdEn; then write 1 to TSR -> irq falls on the next cycle.
REQ-036 Write TCNT=32'hFFFF_FFFF with TCMP=5, EN=1 -> wraps to 0 with no MATCH; a TCNT write coinciding with a tick loads the written value.
REQ-037 Assert rst while counting and during a pending read -> all outputs 0 immediately; no outEn follows.
REQ-038 With TIMER_PWM_EN, TCMP=2 and PERIODIC=1 -> pwm high for 2 of every 3 counts; without the macro, pwm stays 0.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and register layout for the timer peripheral.
package timer_pkg;

   localparam int unsigned ADDR_W     = 12;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned PRESC_W    = 16;
   localparam int unsigned TCR_RSVD_W = DATA_W - PRESC_W - 3;

   localparam logic [ADDR_W-1:0] TCR_ADDR_DFLT  = 12'h504;
   localparam logic [ADDR_W-1:0] TCNT_ADDR_DFLT = 12'h505;
   localparam logic [ADDR_W-1:0] TCMP_ADDR_DFLT = 12'h506;
   localparam logic [ADDR_W-1:0] TSR_ADDR_DFLT  = 12'h507;

   localparam int unsigned TCR_EN_BIT       = 0;
   localparam int unsigned TCR_PERIODIC_BIT = 1;
   localparam int unsigned TCR_IE_BIT       = 2;
   localparam int unsigned TCR_PRESC_LSB    = 16;

   // Bits of TCR that hold state; everything else reads back as zero
   localparam logic [DATA_W-1:0] TCR_WR_MASK =
      (DATA_W'({PRESC_W{1'b1}}) << TCR_PRESC_LSB) |
      (DATA_W'(1) << TCR_IE_BIT) |
      (DATA_W'(1) << TCR_PERIODIC_BIT) |
      (DATA_W'(1) << TCR_EN_BIT);

   typedef struct packed {
      logic [PRESC_W-1:0]    presc;
      logic [TCR_RSVD_W-1:0] rsvd;
      logic                  ie;
      logic                  periodic;
      logic                  en;
   } tcr_t;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: emits a one-cycle tick every presc+1 clocks while en is high.
module timer_prescaler
   import timer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PRESC_W-1:0] presc,
   output logic               tick
);

   logic [PRESC_W-1:0] cnt;

   // >= so that lowering presc mid-count does not run the counter round 2^16
   assign tick = en & (cnt >= presc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/timer_periph.sv
// timer_periph: bus-mapped 32-bit timer with prescaler, compare match and level irq.
// Define TIMER_PWM_EN to build the registered PWM comparator output.
module timer_periph
   import timer_pkg::*;
#(
   parameter logic [ADDR_W-1:0] TCR_ADDR  = TCR_ADDR_DFLT,
   parameter logic [ADDR_W-1:0] TCNT_ADDR = TCNT_ADDR_DFLT,
   parameter logic [ADDR_W-1:0] TCMP_ADDR = TCMP_ADDR_DFLT,
   parameter logic [ADDR_W-1:0] TSR_ADDR  = TSR_ADDR_DFLT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wrData,
   input  logic              wrEn,
   input  logic              rdEn,
   output logic [DATA_W-1:0] dataOut,
   output logic              outEn,
   output logic              irq,
   output logic              pwm
);

   tcr_t              tcr;
   logic [DATA_W-1:0] tcnt;
   logic [DATA_W-1:0] tcmp;
   logic              match;
   logic              tick;
   logic              selTcr, selTcnt, selTcmp, selTsr, hit;
   logic              wrTcr, wrTcnt, wrTcmp, wrTsr;
   logic              matchEvt;
   logic [DATA_W-1:0] rdMux;

   assign selTcr  = (addr == TCR_ADDR);
   assign selTcnt = (addr == TCNT_ADDR);
   assign selTcmp = (addr == TCMP_ADDR);
   assign selTsr  = (addr == TSR_ADDR);
   assign hit     = selTcr | selTcnt | selTcmp | selTsr;

   assign wrTcr  = wrEn & selTcr;
   assign wrTcnt = wrEn & selTcnt;
   assign wrTcmp = wrEn & selTcmp;
   assign wrTsr  = wrEn & selTsr;

   // A core write to TCNT pre-empts both the increment and the compare event
   assign matchEvt = tick & ~wrTcnt & (tcnt == tcmp);

   assign irq = match & tcr.ie;

   timer_prescaler uPresc (
      .clk   (clk),
      .rst   (rst),
      .en    (tcr.en),
      .presc (tcr.presc),
      .tick  (tick)
   );

   always_comb begin
      rdMux = '0;
      if (selTcr) begin
         rdMux = DATA_W'(tcr);
      end else if (selTcnt) begin
         rdMux = tcnt;
      end else if (selTcmp) begin
         rdMux = tcmp;
      end else if (selTsr) begin
         rdMux = DATA_W'(match);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcr     <= '0;
         tcnt    <= '0;
         tcmp    <= '0;
         match   <= 1'b0;
         dataOut <= '0;
         outEn   <= 1'b0;
      end else begin
         if (wrTcr) begin
            tcr <= tcr_t'(wrData & TCR_WR_MASK);
         end else if (matchEvt && !tcr.periodic) begin
            tcr.en <= 1'b0;
         end

         if (wrTcnt) begin
            tcnt <= wrData;
         end else if (tick) begin
            tcnt <= matchEvt ? '0 : tcnt + DATA_W'(1);
         end

         if (wrTcmp) begin
            tcmp <= wrData;
         end

         // Set wins over a simultaneous write-one-to-clear
         if (matchEvt) begin
            match <= 1'b1;
         end else if (wrTsr && wrData[0]) begin
            match <= 1'b0;
         end

         outEn   <= rdEn & hit;
         dataOut <= (rdEn && hit) ? rdMux : '0;
      end
   end

`ifdef TIMER_PWM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm <= 1'b0;
      end else begin
         pwm <= tcr.en & (tcnt < tcmp);
      end
   end
`else
   assign pwm = 1'b0;
`endif

endmodule

// File: tb/tb_timer_periph.sv
// tb_timer_periph: directed and randomized checks of timer_periph against a reference model.
module tb_timer_periph;

   localparam logic [11:0] A_TCR  = 12'h504;
   localparam logic [11:0] A_TCNT = 12'h505;
   localparam logic [11:0] A_TCMP = 12'h506;
   localparam logic [11:0] A_TSR  = 12'h507;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] addr;
   logic [31:0] wrData;
   logic        wrEn;
   logic        rdEn;
   logic [31:0] dataOut;
   logic        outEn;
   logic        irq;
   logic        pwm;

   timer_periph dut (
      .clk     (clk),
      .rst     (rst),
      .addr    (addr),
      .wrData  (wrData),
      .wrEn    (wrEn),
      .rdEn    (rdEn),
      .dataOut (dataOut),
      .outEn   (outEn),
      .irq     (irq),
      .pwm     (pwm)
   );

   always #5 clk = ~clk;

   int nCmp  = 0;
   int nFail = 0;

   // Reference model state, kept as plain numbers
   bit              mEn, mPer, mIe, mMatch;
   int unsigned     mPresc, mPhase;
   longint unsigned mTcnt, mTcmp;
   logic [31:0]     mDataOut;
   bit              mOutEn, mPwm;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mEn = 0; mPer = 0; mIe = 0; mMatch = 0;
      mPresc = 0; mPhase = 0; mTcnt = 0; mTcmp = 0;
      mDataOut = '0; mOutEn = 0; mPwm = 0;
   endtask

   function automatic logic [31:0] mRead(input logic [11:0] a);
      logic [31:0] v;
      logic [31:0] p;
      v = '0;
      p = mPresc;
      case (a)
         A_TCR:  v = {p[15:0], 13'd0, mIe, mPer, mEn};
         A_TCNT: v = 32'(mTcnt);
         A_TCMP: v = 32'(mTcmp);
         A_TSR:  v = {31'd0, mMatch};
         default: v = '0;
      endcase
      return v;
   endfunction

   // Advance the model by one clock given the inputs presented during that clock
   task automatic modelStep(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
      bit hit, tick, wTcnt, evt;
      hit   = (a == A_TCR) || (a == A_TCNT) || (a == A_TCMP) || (a == A_TSR);
      tick  = mEn && (mPhase >= mPresc);
      wTcnt = w && (a == A_TCNT);
      evt   = tick && !wTcnt && (mTcnt == mTcmp);
      mOutEn   = r && hit;
      mDataOut = (r && hit) ? mRead(a) : 32'd0;
`ifdef TIMER_PWM_EN
      mPwm = mEn && (mTcnt < mTcmp);
`else
      mPwm = 0;
`endif
      mPhase = (!mEn || tick) ? 0 : mPhase + 1;
      if (wTcnt) mTcnt = d;
      else if (tick) mTcnt = evt ? 0 : ((mTcnt + 1) & 64'hFFFF_FFFF);
      if (w && a == A_TCR) begin
         mEn = d[0]; mPer = d[1]; mIe = d[2]; mPresc = d[31:16];
      end else if (evt && !mPer) begin
         mEn = 0;
      end
      if (w && a == A_TCMP) mTcmp = d;
      if (evt) mMatch = 1;
      else if (w && a == A_TSR && d[0]) mMatch = 0;
   endtask

   task automatic checkAll();
      chk("dataOut", dataOut, mDataOut);
      chk("outEn", 32'(outEn), 32'(mOutEn));
      chk("irq", 32'(irq), 32'(mMatch & mIe));
      chk("pwm", 32'(pwm), 32'(mPwm));
   endtask

   task automatic cycle(input logic [11:0] a, input logic [31:0] d, input logic w, input logic r);
      addr = a; wrData = d; wrEn = w; rdEn = r;
      @(posedge clk);
      modelStep(a, d, w, r);
      #1;
      wrEn = 1'b0; rdEn = 1'b0;
      checkAll();
   endtask

   logic [11:0] ra;
   logic [31:0] rd;
   int unsigned sel;
   int          hi;

   initial begin
      rst = 1'b1; addr = '0; wrData = '0; wrEn = 1'b0; rdEn = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkAll();
      @(negedge clk);
      rst = 1'b0;

      // Periodic count 0..3 with TCMP=3, IE off
      cycle(A_TCMP, 32'd3, 1, 0);
      cycle(A_TCR, 32'h0000_0003, 1, 0);
      for (int k = 0; k < 9; k++) begin
         cycle(A_TCNT, 32'd0, 0, 1);
         chk("cnt_seq", dataOut, 32'(k % 4));
      end
      cycle(A_TSR, 32'd0, 0, 1);
      chk("match_periodic", dataOut, 32'd1);
      chk("irq_ie_off", 32'(irq), 32'd0);
      cycle(A_TCR, 32'd0, 1, 0);
      cycle(A_TSR, 32'd1, 1, 0);
      cycle(A_TCNT, 32'd0, 1, 0);

      // One-shot, PRESC=2, IE, TCMP=1
      cycle(A_TCMP, 32'd1, 1, 0);
      cycle(A_TCR, 32'h0002_0005, 1, 0);
      for (int k = 1; k <= 6; k++) begin
         cycle(12'h000, 32'd0, 0, 0);
         chk("irq_oneshot", 32'(irq), 32'(k == 6));
      end
      cycle(A_TCR, 32'd0, 0, 1);
      chk("tcr_en_cleared", dataOut, 32'h0002_0004);

      // TSR read latency and write-one-to-clear
      cycle(A_TSR, 32'd0, 0, 1);
      chk("tsr_rd_en", 32'(outEn), 32'd1);
      chk("tsr_rd_data", dataOut, 32'd1);
      cycle(12'h000, 32'd0, 0, 0);
      chk("tsr_rd_gone", 32'(outEn), 32'd0);
      cycle(A_TSR, 32'd0, 1, 0);
      chk("tsr_w0_keeps", 32'(irq), 32'd1);
      cycle(A_TSR, 32'd1, 1, 0);
      chk("tsr_w1_clears", 32'(irq), 32'd0);

      // 32-bit wrap without match, and TCNT write during a tick
      cycle(A_TCR, 32'd0, 1, 0);
      cycle(A_TCMP, 32'd5, 1, 0);
      cycle(A_TCNT, 32'hFFFF_FFFF, 1, 0);
      cycle(A_TCR, 32'h0000_0003, 1, 0);
      cycle(A_TCNT, 32'd0, 0, 1);
      chk("pre_wrap", dataOut, 32'hFFFF_FFFF);
      cycle(A_TCNT, 32'd0, 0, 1);
      chk("post_wrap", dataOut, 32'd0);
      cycle(A_TSR, 32'd0, 0, 1);
      chk("wrap_no_match", dataOut, 32'd0);
      cycle(A_TCNT, 32'h100, 1, 0);
      cycle(A_TCNT, 32'd0, 0, 1);
      chk("tcnt_wr_wins", dataOut, 32'h100);
      cycle(A_TCNT, 32'd5, 1, 0);
      cycle(A_TCNT, 32'd9, 1, 0);
      cycle(A_TSR, 32'd0, 0, 1);
      chk("tcnt_wr_no_match", dataOut, 32'd0);
      cycle(A_TCR, 32'd0, 1, 0);

      // TCMP=0 one-shot; TCR write beats the one-shot EN clear
      cycle(A_TCNT, 32'd0, 1, 0);
      cycle(A_TCMP, 32'd0, 1, 0);
      cycle(A_TCR, 32'h0000_0001, 1, 0);
      cycle(A_TCR, 32'h0000_0001, 1, 0);
      cycle(A_TCR, 32'd0, 0, 1);
      chk("tcr_wr_wins", dataOut, 32'd1);
      cycle(A_TCR, 32'd0, 0, 1);
      chk("oneshot_tcmp0", dataOut, 32'd0);
      cycle(A_TSR, 32'd1, 1, 0);

      // PWM duty with TCMP=2, periodic
      cycle(A_TCNT, 32'd0, 1, 0);
      cycle(A_TCMP, 32'd2, 1, 0);
      cycle(A_TCR, 32'h0000_0003, 1, 0);
      hi = 0;
      for (int k = 0; k < 9; k++) begin
         cycle(12'h000, 32'd0, 0, 0);
         hi += int'(pwm);
      end
`ifdef TIMER_PWM_EN
      chk("pwm_duty", 32'(hi), 32'd6);
`else
      chk("pwm_off", 32'(hi), 32'd0);
`endif

      // Reset while counting with irq high and a read in flight
      cycle(A_TCMP, 32'd0, 1, 0);
      cycle(A_TCR, 32'h0000_0007, 1, 0);
      cycle(A_TCNT, 32'd0, 0, 1);
      chk("pre_rst_outEn", 32'(outEn), 32'd1);
      chk("pre_rst_irq", 32'(irq), 32'd1);
      rst = 1'b1;
      #1;
      modelReset();
      checkAll();
      @(negedge clk);
      rst = 1'b0;
      cycle(A_TCR, 32'h0000_0007, 1, 0);
      cycle(12'h000, 32'd0, 0, 0);
      addr = A_TSR; rdEn = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      #1;
      modelReset();
      checkAll();
      @(posedge clk);
      #1;
      chk("rst_no_outEn", 32'(outEn), 32'd0);
      rdEn = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cycle(A_TCR, 32'd0, 0, 1);
      chk("tcr_after_rst", dataOut, 32'd0);

      // Randomized register traffic
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 4);
         rd  = $urandom;
         case (sel)
            0: begin ra = A_TCR; rd[31:16] = 16'($urandom_range(0, 3)); end
            1: begin ra = A_TCNT; rd = $urandom_range(0, 7); end
            2: begin ra = A_TCMP; rd = $urandom_range(0, 7); end
            3: ra = A_TSR;
            default: ra = 12'($urandom);
         endcase
         cycle(ra, rd, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
      $finish;
   end

endmodule
